// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler.
// Walks a k x k window across the image in row-major order. For each window
// it programs the TPU lane addresses, starts the TPU, waits for completion
// and then hands the lane-0 result to the consumer through a valid/ready port.
module conv_window_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 5,
    parameter int IMAGE_HEIGHT = 5,
    parameter int NUM_UNITS    = 9,
    parameter int TIMEOUT      = 255,
    localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    localparam int KW = $clog2(IMAGE_WIDTH),
    localparam int LW = $clog2(NUM_UNITS) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [KW-1:0]             cmd_kernel_dim,
    output logic [NUM_UNITS*AW-1:0]   tpu_start_addr_1,
    output logic [NUM_UNITS*AW-1:0]   tpu_start_addr_2,
    output logic                      tpu_read_mem1,
    output logic                      tpu_read_mem2,
    output logic [NUM_UNITS-1:0]      tpu_active_units,
    output logic [LW-1:0]             tpu_length,
    output logic                      tpu_start,
    input  logic                      tpu_done,
    input  logic [DATA_WIDTH-1:0]     tpu_result,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_WIDTH-1:0]     res_data,
    output logic [AW-1:0]             res_addr,
    output logic                      busy,
    output logic                      error
);

    localparam int RW      = $clog2(IMAGE_HEIGHT + 1);
    localparam int CW      = $clog2(IMAGE_WIDTH + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int MIN_DIM = (IMAGE_WIDTH < IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, EMIT, NEXT} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   r_q, r_d;
    logic [CW-1:0]   c_q, c_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            ready_q;
    logic            err_d;
    logic            res_cap;
    logic            k_legal;
    logic            c_last;
    logic            r_last;
    logic [AW-1:0]   res_addr_d;

    logic [NUM_UNITS*AW-1:0] addr1_d;
    logic [NUM_UNITS*AW-1:0] addr2_d;
    logic [NUM_UNITS-1:0]    mask_d;
    logic [LW-1:0]           len_d;

    // Kernel legality and window-position decode
    always_comb begin
        k_legal = (32'(cmd_kernel_dim) >= 32'd1) &&
                  (32'(cmd_kernel_dim) <= 32'(MIN_DIM)) &&
                  (32'(cmd_kernel_dim) * 32'(cmd_kernel_dim) <= 32'(NUM_UNITS));
        c_last     = (32'(c_q) == 32'(IMAGE_WIDTH) - 32'(k_q));
        r_last     = (32'(r_q) == 32'(IMAGE_HEIGHT) - 32'(k_q));
        res_addr_d = AW'(32'(r_q) * (32'(IMAGE_WIDTH) - 32'(k_q) + 32'd1) + 32'(c_q));
    end

    // Next-state, window counters and FSM-decoded outputs
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        r_d           = r_q;
        c_d           = c_q;
        cnt_d         = cnt_q;
        err_d         = 1'b0;
        res_cap       = 1'b0;
        cmd_ready     = 1'b0;
        tpu_start     = 1'b0;
        tpu_read_mem1 = 1'b0;
        tpu_read_mem2 = 1'b0;
        res_valid     = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                cmd_ready = ready_q;
                if (cmd_valid && ready_q) begin
                    if (k_legal) begin
                        k_d     = cmd_kernel_dim;
                        r_d     = '0;
                        c_d     = '0;
                        state_d = SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                tpu_read_mem1 = 1'b1;
                tpu_read_mem2 = 1'b1;
                state_d       = START;
            end
            START: begin
                tpu_read_mem1 = 1'b1;
                tpu_read_mem2 = 1'b1;
                tpu_start     = 1'b1;
                cnt_d         = '0;
                state_d       = WAIT;
            end
            WAIT: begin
                tpu_read_mem1 = 1'b1;
                tpu_read_mem2 = 1'b1;
                if (tpu_done) begin
                    res_cap = 1'b1;
                    state_d = EMIT;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            EMIT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (c_last && r_last) begin
                    state_d = IDLE;
                end else begin
                    if (c_last) begin
                        c_d = '0;
                        r_d = r_q + RW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                    state_d = SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane address/mask generation for the window about to be loaded;
    // row/col walk the kernel incrementally so no divider is needed.
    always_comb begin
        int unsigned kk;
        int unsigned row;
        int unsigned col;
        addr1_d = '0;
        addr2_d = '0;
        mask_d  = '0;
        kk      = 32'(k_d);
        row     = 0;
        col     = 0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (u < kk * kk) begin
                addr1_d[u*AW +: AW] = AW'((32'(r_d) + row) * 32'(IMAGE_WIDTH) + 32'(c_d) + col);
                addr2_d[u*AW +: AW] = AW'(u);
                mask_d[u]           = 1'b1;
                if (col == kk - 1) begin
                    col = 0;
                    row = row + 1;
                end else begin
                    col = col + 1;
                end
            end
        end
        len_d = LW'(kk * kk);
    end

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end

    // Registered TPU programming, result capture and error pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            tpu_start_addr_1 <= '0;
            tpu_start_addr_2 <= '0;
            tpu_active_units <= '0;
            tpu_length       <= '0;
            res_data         <= '0;
            res_addr         <= '0;
            error            <= 1'b0;
        end else begin
            error <= err_d;
            if (state_d == SETUP) begin
                tpu_start_addr_1 <= addr1_d;
                tpu_start_addr_2 <= addr2_d;
                tpu_active_units <= mask_d;
                tpu_length       <= len_d;
            end
            if (res_cap) begin
                res_data <= tpu_result;
                res_addr <= res_addr_d;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler: TPU stand-in, window model
// derived from the addressing rules, and directed job scenarios.
module tb_conv_window_scheduler;

    localparam int DW = 16;
    localparam int IW = 5;
    localparam int IH = 5;
    localparam int NU = 9;
    localparam int TO = 255;
    localparam int AW = $clog2(IW * IH);
    localparam int KW = $clog2(IW);
    localparam int LW = $clog2(NU) + 1;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [KW-1:0]     cmd_kernel_dim;
    logic [NU*AW-1:0]  addr1;
    logic [NU*AW-1:0]  addr2;
    logic              rd1;
    logic              rd2;
    logic [NU-1:0]     active;
    logic [LW-1:0]     length;
    logic              tpu_start;
    logic              tpu_done;
    logic [DW-1:0]     tpu_result;
    logic              res_valid;
    logic              res_ready;
    logic [DW-1:0]     res_data;
    logic [AW-1:0]     res_addr;
    logic              busy;
    logic              error;

    conv_window_scheduler #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .NUM_UNITS(NU), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kernel_dim(cmd_kernel_dim),
        .tpu_start_addr_1(addr1), .tpu_start_addr_2(addr2),
        .tpu_read_mem1(rd1), .tpu_read_mem2(rd2),
        .tpu_active_units(active), .tpu_length(length), .tpu_start(tpu_start),
        .tpu_done(tpu_done), .tpu_result(tpu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_addr(res_addr),
        .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int m_k         = 1;
    int n_starts    = 0;
    int n_results   = 0;
    int n_err       = 0;
    int tpu_seq     = 0;
    bit tpu_en      = 1'b1;

    logic [NU*AW-1:0] snap_first;
    logic [NU*AW-1:0] snap_last;
    logic [NU-1:0]    snap_mask;
    logic [LW-1:0]    snap_len;

    int exp_k3_w0[NU] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    int exp_k3_w8[NU] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    int exp_k2_w0[NU] = '{0, 1, 5, 6, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected addresses straight from the window formula.
    function automatic logic [NU*AW-1:0] exp_addr1(input int k, input int w);
        logic [NU*AW-1:0] v;
        int nw;
        int r;
        int c;
        v  = '0;
        nw = IW - k + 1;
        r  = w / nw;
        c  = w % nw;
        for (int u = 0; u < k * k; u++) v[u*AW +: AW] = AW'((r + u / k) * IW + c + u % k);
        return v;
    endfunction

    function automatic logic [NU*AW-1:0] exp_addr2(input int k);
        logic [NU*AW-1:0] v;
        v = '0;
        for (int u = 0; u < k * k; u++) v[u*AW +: AW] = AW'(u);
        return v;
    endfunction

    function automatic int exp_res_addr(input int k, input int w);
        int nw;
        nw = IW - k + 1;
        return (w / nw) * nw + (w % nw);
    endfunction

    function automatic int lane(input logic [NU*AW-1:0] v, input int u);
        return int'(v[u*AW +: AW]);
    endfunction

    task automatic chk_lanes(input string name, input logic [NU*AW-1:0] v, input int e[NU]);
        for (int u = 0; u < NU; u++) chk(name, 64'(lane(v, u)), 64'(e[u]));
    endtask

    // TPU stand-in: done arrives on the 4th cycle after the start cycle,
    // result encodes the start sequence number within the job.
    initial begin
        tpu_done   = 1'b0;
        tpu_result = '0;
        forever begin
            @(negedge clk);
            if (tpu_start && tpu_en && reset) begin
                repeat (3) @(negedge clk);
                tpu_result = 16'h1000 + DW'(tpu_seq);
                tpu_done   = 1'b1;
                @(negedge clk);
                tpu_done = 1'b0;
                tpu_seq++;
            end
        end
    end

    // Compare process: every TPU start and every result handshake checked against the model
    always @(negedge clk) begin
        if (reset) begin
            if (tpu_start) begin
                chk("start_order", 64'(n_starts), 64'(n_results));
                chk("addr1", 64'(addr1), 64'(exp_addr1(m_k, n_starts)));
                chk("addr2", 64'(addr2), 64'(exp_addr2(m_k)));
                chk("active", 64'(active), (64'd1 << (m_k * m_k)) - 64'd1);
                chk("length", 64'(length), 64'(m_k * m_k));
                chk("rd_mem", 64'({rd1, rd2}), 64'd3);
                if (n_starts == 0) snap_first = addr1;
                snap_last = addr1;
                snap_mask = active;
                snap_len  = length;
                n_starts++;
            end
            if (res_valid && res_ready) begin
                chk("res_addr", 64'(res_addr), 64'(exp_res_addr(m_k, n_results)));
                chk("res_data", 64'(res_data), 64'(16'h1000 + n_results));
                n_results++;
            end
            if (error) n_err++;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_start"}, 64'(tpu_start), 64'd0);
        chk({tag, "_rd"}, 64'({rd1, rd2}), 64'd0);
        chk({tag, "_active"}, 64'(active), 64'd0);
        chk({tag, "_length"}, 64'(length), 64'd0);
        chk({tag, "_addr1"}, 64'(addr1), 64'd0);
        chk({tag, "_addr2"}, 64'(addr2), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_data"}, 64'(res_data), 64'd0);
        chk({tag, "_res_addr"}, 64'(res_addr), 64'd0);
    endtask

    task automatic new_job(input int k);
        m_k       = k;
        n_starts  = 0;
        n_results = 0;
        n_err     = 0;
        tpu_seq   = 0;
    endtask

    // Returns at #1 after the edge that samples the command.
    task automatic issue_cmd(input int k);
        bit rdy;
        rdy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                rdy = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("cmd_ready_wait", 64'(rdy), 64'd1);
        cmd_valid      = 1'b1;
        cmd_kernel_dim = KW'(k);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_job(input int k, input int hold_w);
        bit ok;
        bit held;
        new_job(k);
        res_ready = 1'b1;
        issue_cmd(k);
        ok   = 1'b0;
        held = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            if (hold_w >= 0 && !held && res_valid && n_results == hold_w) begin
                res_ready = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    chk("hold_valid", 64'(res_valid), 64'd1);
                    chk("hold_data", 64'(res_data), 64'(16'h1000 + hold_w));
                    chk("hold_addr", 64'(res_addr), 64'(exp_res_addr(k, hold_w)));
                    chk("hold_no_start", 64'(tpu_start), 64'd0);
                    chk("hold_addr1", 64'(addr1), 64'(exp_addr1(k, hold_w)));
                end
                res_ready = 1'b1;
                held      = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("job_done", 64'(ok), 64'd1);
        if (hold_w >= 0) chk("job_held", 64'(held), 64'd1);
    endtask

    task automatic illegal_cmd(input int k);
        new_job(k);
        issue_cmd(k);
        chk("ill_error", 64'(error), 64'd1);
        chk("ill_ready", 64'(cmd_ready), 64'd1);
        chk("ill_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("ill_error_clr", 64'(error), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("ill_no_start", 64'(n_starts), 64'd0);
        chk("ill_err_cycles", 64'(n_err), 64'd1);
        chk("ill_ready_after", 64'(cmd_ready), 64'd1);
    endtask

    task automatic timeout_job();
        bit found;
        bit early;
        tpu_en = 1'b0;
        new_job(3);
        issue_cmd(3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tpu_start) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("to_start_seen", 64'(found), 64'd1);
        early = 1'b0;
        @(posedge clk);
        for (int i = 1; i < TO; i++) begin
            @(posedge clk);
            #1;
            if (error || !busy) early = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("to_early", 64'(early), 64'd0);
        chk("to_error", 64'(error), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk("to_error_clr", 64'(error), 64'd0);
        chk("to_ready", 64'(cmd_ready), 64'd1);
        chk("to_no_result", 64'(n_results), 64'd0);
        chk("to_err_cycles", 64'(n_err), 64'd1);
        tpu_en = 1'b1;
    endtask

    task automatic reset_mid_wait();
        int seen;
        bit stray;
        new_job(3);
        issue_cmd(3);
        seen = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (tpu_start) begin
                seen++;
                if (seen == 5) break;
            end
            @(posedge clk);
            #1;
        end
        chk("rst_w4_reached", 64'(seen), 64'd5);
        @(posedge clk);
        #1;
        chk("rst_in_wait_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_ready_lag", 64'(cmd_ready), 64'd0);
        stray = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (res_valid || busy) stray = 1'b1;
        end
        chk("rst_mid_no_partial", 64'(stray), 64'd0);
        chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
        chk("rst_mid_starts", 64'(n_starts), 64'd5);
        chk("rst_mid_results", 64'(n_results), 64'd4);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_kernel_dim = '0;
        res_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        #1;
        chk("ready_lag", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        run_job(3, -1);
        chk("k3_starts", 64'(n_starts), 64'd9);
        chk("k3_results", 64'(n_results), 64'd9);
        chk("k3_err", 64'(n_err), 64'd0);
        chk_lanes("k3_w0_lane", snap_first, exp_k3_w0);
        chk_lanes("k3_w8_lane", snap_last, exp_k3_w8);
        chk("k3_active", 64'(snap_mask), 64'h1FF);
        chk("k3_length", 64'(snap_len), 64'd9);

        run_job(1, -1);
        chk("k1_starts", 64'(n_starts), 64'd25);
        chk("k1_results", 64'(n_results), 64'd25);
        chk("k1_active", 64'(snap_mask), 64'h001);
        chk("k1_length", 64'(snap_len), 64'd1);
        chk("k1_last_lane0", 64'(lane(snap_last, 0)), 64'd24);

        illegal_cmd(4);
        illegal_cmd(0);

        run_job(3, 2);
        chk("bp_results", 64'(n_results), 64'd9);
        chk("bp_starts", 64'(n_starts), 64'd9);

        timeout_job();

        reset_mid_wait();

        run_job(2, -1);
        chk("k2_starts", 64'(n_starts), 64'd16);
        chk("k2_results", 64'(n_results), 64'd16);
        chk_lanes("k2_w0_lane", snap_first, exp_k2_w0);
        chk("k2_active", 64'(snap_mask), 64'h00F);
        chk("k2_length", 64'(snap_len), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_window_scheduler.md
CONV_WINDOW_SCHEDULER -- requirements
Module: conv_window_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, element width (FP16).
REQ-002 SHALL have parameter IMAGE_WIDTH, default 5, image columns.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 5, image rows.
REQ-004 SHALL have parameter NUM_UNITS, default 9, TPU lane count.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for tpu_done.
REQ-006 SHALL use derived widths AW = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), KW = $clog2(IMAGE_WIDTH) and LW = $clog2(NUM_UNITS)+1.
REQ-007 SHALL have clk  in  1  single clock; all logic on its rising edge.
REQ-008 SHALL have reset  in  1  synchronous, active-low reset (reset==0 resets).
REQ-009 SHALL have cmd_valid/cmd_ready  in/out  1/1  job request handshake.
REQ-010 SHALL have cmd_kernel_dim  in  KW  kernel side k.
REQ-011 SHALL have tpu_start_addr_1 and tpu_start_addr_2  out  NUM_UNITS x AW  per-lane image and kernel addresses.
REQ-012 SHALL have tpu_read_mem1 and tpu_read_mem2  out  1 each  TPU memory read enables.
REQ-013 SHALL have tpu_active_units  out  NUM_UNITS  lane mask.
REQ-014 SHALL have tpu_length  out  LW  MAC length.
REQ-015 SHALL have tpu_start  out  1  start pulse.
REQ-016 SHALL have tpu_done  in  1  TPU completion.
REQ-017 SHALL have tpu_result  in  DATA_WIDTH  lane-0 ReLU output.
REQ-018 SHALL have res_valid/res_ready  out/in  1/1  result handshake.
REQ-019 SHALL have res_data  out  DATA_WIDTH  result value.
REQ-020 SHALL have res_addr  out  AW  output pixel index.
REQ-021 SHALL have busy  out  1  job in progress.
REQ-022 SHALL have error  out  1  one-cycle pulse on illegal k or timeout.

Function
REQ-023 SHALL implement FSM states IDLE, SETUP, START, WAIT, EMIT, NEXT.
REQ-024 IDLE: cmd_ready=1; on cmd_valid, legal k (1<=k<=min(IMAGE_WIDTH,IMAGE_HEIGHT), k*k<=NUM_UNITS) SHALL latch k, clear r=c=0, go SETUP; illegal k SHALL pulse error one cycle and stay IDLE.
REQ-025 SHALL drive, for window (r,c) and lane u<k*k, tpu_start_addr_1[u]=(r+u/k)*IMAGE_WIDTH+(c+u%k) and tpu_start_addr_2[u]=u; lanes u>=k*k SHALL be 0.
REQ-026 SHALL drive tpu_active_units with bits [k*k-1:0] set and all others clear, and tpu_length=k*k.
REQ-027 SHALL hold tpu_start_addr_*, tpu_active_units and tpu_length registered and stable from SETUP through EMIT.
REQ-028 SETUP SHALL last exactly one cycle with tpu_read_mem1=tpu_read_mem2=1, then go START.
REQ-029 START SHALL assert tpu_start for exactly one cycle, then go WAIT.
REQ-030 tpu_read_mem1/2 SHALL stay 1 from SETUP through WAIT.
REQ-031 WAIT SHALL count cycles; on tpu_done it SHALL capture tpu_result into res_data, set res_addr=r*(IMAGE_WIDTH-k+1)+c, and go EMIT.
REQ-032 WAIT SHALL, if the counter reaches TIMEOUT before tpu_done, pulse error, abort the job and go IDLE.
REQ-033 EMIT: res_valid=1 with res_data/res_addr stable until res_ready; on the handshake cycle it SHALL go NEXT; backpressure SHALL be unbounded.
REQ-034 NEXT SHALL set c=c+1; at c==IMAGE_WIDTH-k it SHALL set c=0 and r=r+1; after the last window (r==IMAGE_HEIGHT-k, c==IMAGE_WIDTH-k) it SHALL go IDLE, else SETUP; it takes one cycle.
REQ-035 cmd_valid outside IDLE SHALL be ignored, with cmd_ready=0.
REQ-036 tpu_done outside WAIT SHALL be ignored.
REQ-037 busy SHALL be 1 in every state except IDLE.

Reset
REQ-038 On reset==0 at a clock edge the block SHALL enter IDLE from any state, including mid-WAIT and mid-EMIT.
REQ-039 On reset==0 the FSM SHALL clear r, c and the timeout counter.
REQ-040 On reset==0 every output SHALL be 0, except cmd_ready, which SHALL be 1 one cycle after reset rises.
REQ-041 No partial result SHALL be emitted after reset.

Verification
REQ-042 k=3, 5x5, tpu_done 4 cycles after start, res_ready=1 -> 9 results, res_addr 0..8; window 0 addr1 {0,1,2,5,6,7,10,11,12}, window 8 addr1 {12,13,14,17,18,19,22,23,24}; active_units=9'h1FF, length=9.
REQ-043 k=1 -> 25 results, res_addr 0..24, active_units=9'h001, length=1, addr1[0]=res_addr.
REQ-044 k=4 -> error pulse 1 cycle, no tpu_start, cmd_ready stays 1; k=0 -> same.
REQ-045 k=3 with res_ready held 0 for 10 cycles in window 2 -> res_valid, res_data, res_addr stable; no tpu_start until handshake.
REQ-046 tpu_done never asserted -> error pulses exactly TIMEOUT cycles after entering WAIT, then IDLE, busy=0.
REQ-047 reset low during WAIT of window 4 -> next cycle all outputs 0; new k=2 job starts at window 0 with addr1 {0,1,5,6}.
